// File: rtl/control_unit_pkg.sv
// Shared types and constants for the core control unit: ALU ops, bus sources,
// opcodes, register-enable bit positions and the packed control word.
package details;

    localparam int unsigned OPC_W = 8;
    localparam int unsigned WR_W  = 10;
    localparam int unsigned INC_W = 4;

    typedef enum logic [2:0] {
        ALU_IDLE,
        CLR,
        PASS,
        ADD,
        SUB,
        MUL,
        INC
    } alu_op_t;

    typedef enum logic [3:0] {
        BUS_DM,
        BUS_R,
        BUS_IR,
        BUS_RL,
        BUS_RC,
        BUS_RP,
        BUS_RQ,
        BUS_R1,
        BUS_AC
    } bus_in_sel_t;

    // wrEnReg bit positions
    localparam int unsigned WR_AC = 0;
    localparam int unsigned WR_R1 = 1;
    localparam int unsigned WR_RQ = 2;
    localparam int unsigned WR_RP = 3;
    localparam int unsigned WR_RC = 4;
    localparam int unsigned WR_RL = 5;
    localparam int unsigned WR_IR = 6;
    localparam int unsigned WR_PC = 7;
    localparam int unsigned WR_R  = 8;
    localparam int unsigned WR_AR = 9;

    // incReg bit positions
    localparam int unsigned INC_RQ = 0;
    localparam int unsigned INC_RP = 1;
    localparam int unsigned INC_RC = 2;
    localparam int unsigned INC_PC = 3;

    localparam logic [OPC_W-1:0] OP_NOP      = 8'h00;
    localparam logic [OPC_W-1:0] OP_ENDOP    = 8'h01;
    localparam logic [OPC_W-1:0] OP_CLAC     = 8'h02;
    localparam logic [OPC_W-1:0] OP_LDIAC    = 8'h03;
    localparam logic [OPC_W-1:0] OP_LDAC     = 8'h04;
    localparam logic [OPC_W-1:0] OP_STR      = 8'h05;
    localparam logic [OPC_W-1:0] OP_STIR     = 8'h06;
    localparam logic [OPC_W-1:0] OP_JUMP     = 8'h07;
    localparam logic [OPC_W-1:0] OP_JMPNZ    = 8'h08;
    localparam logic [OPC_W-1:0] OP_JMPZ     = 8'h09;
    localparam logic [OPC_W-1:0] OP_MUL      = 8'h0A;
    localparam logic [OPC_W-1:0] OP_ADD      = 8'h0B;
    localparam logic [OPC_W-1:0] OP_SUB      = 8'h0C;
    localparam logic [OPC_W-1:0] OP_INCAC    = 8'h0D;
    localparam logic [OPC_W-1:0] OP_MV_RL_AC = 8'h1F;
    localparam logic [OPC_W-1:0] OP_MV_RP_AC = 8'h2F;
    localparam logic [OPC_W-1:0] OP_MV_RQ_AC = 8'h3F;
    localparam logic [OPC_W-1:0] OP_MV_RC_AC = 8'h4F;
    localparam logic [OPC_W-1:0] OP_MV_R_AC  = 8'h5F;
    localparam logic [OPC_W-1:0] OP_MV_R1_AC = 8'h6F;
    localparam logic [OPC_W-1:0] OP_MV_AC_RP = 8'h7F;
    localparam logic [OPC_W-1:0] OP_MV_AC_RQ = 8'h8F;
    localparam logic [OPC_W-1:0] OP_MV_AC_RL = 8'h9F;
    localparam logic [OPC_W-1:0] OP_INCRC    = 8'hAF;
    localparam logic [OPC_W-1:0] OP_INCRP    = 8'hBF;
    localparam logic [OPC_W-1:0] OP_INCRQ    = 8'hCF;

    typedef struct packed {
        alu_op_t           alu_op;
        logic [WR_W-1:0]   wr_en;
        logic [INC_W-1:0]  inc;
        bus_in_sel_t       bus_sel;
        logic              dm_wr;
        logic              z_wr;
        logic              done;
        logic              ready;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{
        alu_op:  ALU_IDLE,
        wr_en:   '0,
        inc:     '0,
        bus_sel: BUS_DM,
        dm_wr:   1'b0,
        z_wr:    1'b0,
        done:    1'b0,
        ready:   1'b0
    };

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore control unit for one accumulator core: fetch, decode, execute.
// Optional INC_REGS_EN adds the INCRC/INCRP/INCRQ instructions.
module control_unit
    import details::*;
#(
    parameter int unsigned IR_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                start,
    input  logic                Zout,
    input  logic [IR_WIDTH-1:0] ins,
    output alu_op_t             aluOp,
    output logic [INC_W-1:0]    incReg,
    output logic [WR_W-1:0]     wrEnReg,
    output bus_in_sel_t         busSel,
    output logic                DataMemWrEn,
    output logic                ZWrEn,
    output logic                done,
    output logic                ready
);

    typedef enum logic [5:0] {
        S_IDLE, S_FETCH1, S_FETCH2, S_FETCH3,
        S_NOP, S_END, S_CLAC,
        S_LDIAC1, S_LDIAC2, S_LDIAC3, S_LDIAC4, S_LDIAC5,
        S_LDAC1, S_LDAC2, S_LDAC3,
        S_STR1, S_STR2, S_STR3,
        S_STIR1, S_STIR2, S_STIR3, S_STIR4, S_STIR5,
        S_JMP1, S_JMP2, S_JMP3, S_SKIP,
        S_MUL, S_ADD, S_SUB, S_INCAC,
        S_MV_RL_AC, S_MV_RP_AC, S_MV_RQ_AC, S_MV_RC_AC, S_MV_R_AC, S_MV_R1_AC,
        S_MV_AC_RP, S_MV_AC_RQ, S_MV_AC_RL,
        S_INCRC, S_INCRP, S_INCRQ
    } state_t;

    state_t state_q, state_nxt;
    ctrl_t  ctrl_q, ctrl_nxt;

    logic [OPC_W-1:0] opcode;
    logic             unused_ins;

    assign opcode     = ins[OPC_W-1:0];
    assign unused_ins = ^ins;

    // First execute state for an opcode; anything unrecognised runs as NOP.
    function automatic state_t decode_op(input logic [OPC_W-1:0] op, input logic z);
        state_t s;
        case (op)
            OP_ENDOP:    s = S_END;
            OP_CLAC:     s = S_CLAC;
            OP_LDIAC:    s = S_LDIAC1;
            OP_LDAC:     s = S_LDAC1;
            OP_STR:      s = S_STR1;
            OP_STIR:     s = S_STIR1;
            OP_JUMP:     s = S_JMP1;
            OP_JMPNZ:    s = z ? S_SKIP : S_JMP1;
            OP_JMPZ:     s = z ? S_JMP1 : S_SKIP;
            OP_MUL:      s = S_MUL;
            OP_ADD:      s = S_ADD;
            OP_SUB:      s = S_SUB;
            OP_INCAC:    s = S_INCAC;
            OP_MV_RL_AC: s = S_MV_RL_AC;
            OP_MV_RP_AC: s = S_MV_RP_AC;
            OP_MV_RQ_AC: s = S_MV_RQ_AC;
            OP_MV_RC_AC: s = S_MV_RC_AC;
            OP_MV_R_AC:  s = S_MV_R_AC;
            OP_MV_R1_AC: s = S_MV_R1_AC;
            OP_MV_AC_RP: s = S_MV_AC_RP;
            OP_MV_AC_RQ: s = S_MV_AC_RQ;
            OP_MV_AC_RL: s = S_MV_AC_RL;
`ifdef INC_REGS_EN
            OP_INCRC:    s = S_INCRC;
            OP_INCRP:    s = S_INCRP;
            OP_INCRQ:    s = S_INCRQ;
`endif
            default:     s = S_NOP;
        endcase
        return s;
    endfunction

    // State register plus a control word registered from the next state,
    // so outputs track the state they belong to without decode glitches.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q        <= S_IDLE;
            ctrl_q         <= CTRL_DEFAULT;
            ctrl_q.ready   <= 1'b1;
        end else begin
            state_q <= state_nxt;
            ctrl_q  <= ctrl_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        ctrl_nxt  = CTRL_DEFAULT;

        case (state_q)
            S_IDLE:   if (start) state_nxt = S_FETCH1;
            S_FETCH1: state_nxt = S_FETCH2;
            S_FETCH2: state_nxt = S_FETCH3;
            S_FETCH3: state_nxt = decode_op(opcode, Zout);
            S_END:    state_nxt = S_IDLE;
            S_LDIAC1: state_nxt = S_LDIAC2;
            S_LDIAC2: state_nxt = S_LDIAC3;
            S_LDIAC3: state_nxt = S_LDIAC4;
            S_LDIAC4: state_nxt = S_LDIAC5;
            S_LDAC1:  state_nxt = S_LDAC2;
            S_LDAC2:  state_nxt = S_LDAC3;
            S_STR1:   state_nxt = S_STR2;
            S_STR2:   state_nxt = S_STR3;
            S_STIR1:  state_nxt = S_STIR2;
            S_STIR2:  state_nxt = S_STIR3;
            S_STIR3:  state_nxt = S_STIR4;
            S_STIR4:  state_nxt = S_STIR5;
            S_JMP1:   state_nxt = S_JMP2;
            S_JMP2:   state_nxt = S_JMP3;
            default:  state_nxt = S_FETCH1;
        endcase

        // Control word for the state about to be entered.
        case (state_nxt)
            S_IDLE:   ctrl_nxt.ready = 1'b1;
            S_FETCH2, S_LDIAC1, S_STIR1, S_JMP1: begin
                ctrl_nxt.wr_en[WR_IR] = 1'b1;
                ctrl_nxt.inc[INC_PC]  = 1'b1;
            end
            S_END:    ctrl_nxt.done = 1'b1;
            S_CLAC: begin
                ctrl_nxt.alu_op       = CLR;
                ctrl_nxt.wr_en[WR_AC] = 1'b1;
                ctrl_nxt.z_wr         = 1'b1;
            end
            S_LDIAC2, S_STIR2: begin
                ctrl_nxt.bus_sel      = BUS_IR;
                ctrl_nxt.wr_en[WR_AR] = 1'b1;
            end
            S_LDIAC4, S_LDAC2: begin
                ctrl_nxt.bus_sel     = BUS_DM;
                ctrl_nxt.wr_en[WR_R] = 1'b1;
            end
            S_LDIAC5, S_LDAC3: begin
                ctrl_nxt.bus_sel      = BUS_R;
                ctrl_nxt.alu_op       = PASS;
                ctrl_nxt.wr_en[WR_AC] = 1'b1;
            end
            S_STR1, S_STIR3: begin
                ctrl_nxt.bus_sel     = BUS_AC;
                ctrl_nxt.wr_en[WR_R] = 1'b1;
            end
            S_STR2, S_STIR4: ctrl_nxt.dm_wr = 1'b1;
            S_JMP2: begin
                ctrl_nxt.bus_sel      = BUS_IR;
                ctrl_nxt.wr_en[WR_PC] = 1'b1;
            end
            S_SKIP:   ctrl_nxt.inc[INC_PC] = 1'b1;
            S_MUL, S_ADD, S_SUB: begin
                ctrl_nxt.bus_sel      = BUS_R;
                ctrl_nxt.alu_op       = (state_nxt == S_MUL) ? MUL :
                                        (state_nxt == S_ADD) ? ADD : SUB;
                ctrl_nxt.wr_en[WR_AC] = 1'b1;
                ctrl_nxt.z_wr         = 1'b1;
            end
            S_INCAC: begin
                ctrl_nxt.alu_op       = INC;
                ctrl_nxt.wr_en[WR_AC] = 1'b1;
                ctrl_nxt.z_wr         = 1'b1;
            end
            S_MV_RL_AC: begin ctrl_nxt.bus_sel = BUS_AC; ctrl_nxt.wr_en[WR_RL] = 1'b1; end
            S_MV_RP_AC: begin ctrl_nxt.bus_sel = BUS_AC; ctrl_nxt.wr_en[WR_RP] = 1'b1; end
            S_MV_RQ_AC: begin ctrl_nxt.bus_sel = BUS_AC; ctrl_nxt.wr_en[WR_RQ] = 1'b1; end
            S_MV_RC_AC: begin ctrl_nxt.bus_sel = BUS_AC; ctrl_nxt.wr_en[WR_RC] = 1'b1; end
            S_MV_R_AC:  begin ctrl_nxt.bus_sel = BUS_AC; ctrl_nxt.wr_en[WR_R]  = 1'b1; end
            S_MV_R1_AC: begin ctrl_nxt.bus_sel = BUS_AC; ctrl_nxt.wr_en[WR_R1] = 1'b1; end
            S_MV_AC_RP, S_MV_AC_RQ, S_MV_AC_RL: begin
                ctrl_nxt.bus_sel      = (state_nxt == S_MV_AC_RP) ? BUS_RP :
                                        (state_nxt == S_MV_AC_RQ) ? BUS_RQ : BUS_RL;
                ctrl_nxt.alu_op       = PASS;
                ctrl_nxt.wr_en[WR_AC] = 1'b1;
            end
`ifdef INC_REGS_EN
            S_INCRC:  ctrl_nxt.inc[INC_RC] = 1'b1;
            S_INCRP:  ctrl_nxt.inc[INC_RP] = 1'b1;
            S_INCRQ:  ctrl_nxt.inc[INC_RQ] = 1'b1;
`endif
            default: ;
        endcase
    end

    assign aluOp       = ctrl_q.alu_op;
    assign incReg      = ctrl_q.inc;
    assign wrEnReg     = ctrl_q.wr_en;
    assign busSel      = ctrl_q.bus_sel;
    assign DataMemWrEn = ctrl_q.dm_wr;
    assign ZWrEn       = ctrl_q.z_wr;
    assign done        = ctrl_q.done;
    assign ready       = ctrl_q.ready;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-cycle control vectors from an instruction-level
// reference table, directed cases followed by a random instruction stream.
module tb_control_unit;
    import details::*;

    localparam int unsigned IRW = 10;

    // Register masks/increments as listed in the port description.
    localparam logic [9:0] M_AR = 10'h200, M_R  = 10'h100, M_PC = 10'h080, M_IR = 10'h040;
    localparam logic [9:0] M_RL = 10'h020, M_RC = 10'h010, M_RP = 10'h008, M_RQ = 10'h004;
    localparam logic [9:0] M_R1 = 10'h002, M_AC = 10'h001, M_NONE = 10'h000;
    localparam logic [3:0] I_PC = 4'h8, I_RC = 4'h4, I_RP = 4'h2, I_RQ = 4'h1, I_NONE = 4'h0;

    typedef struct packed {
        alu_op_t     alu;
        bus_in_sel_t bus;
        logic [9:0]  wr;
        logic [3:0]  inc;
        logic        dm;
        logic        zw;
        logic        dn;
        logic        rdy;
    } vec_t;

    logic            clk = 1'b0;
    logic            rstN;
    logic            start;
    logic            Zout;
    logic [IRW-1:0]  ins;
    alu_op_t         aluOp;
    logic [3:0]      incReg;
    logic [9:0]      wrEnReg;
    bus_in_sel_t     busSel;
    logic            DataMemWrEn;
    logic            ZWrEn;
    logic            done;
    logic            ready;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t exp_q[$];

    control_unit #(.IR_WIDTH(IRW)) dut (
        .clk(clk), .rstN(rstN), .start(start), .Zout(Zout), .ins(ins),
        .aluOp(aluOp), .incReg(incReg), .wrEnReg(wrEnReg), .busSel(busSel),
        .DataMemWrEn(DataMemWrEn), .ZWrEn(ZWrEn), .done(done), .ready(ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(alu_op_t a, bus_in_sel_t b, logic [9:0] w, logic [3:0] i,
                                logic dm, logic zw, logic dn, logic rdy);
        vec_t v;
        v = '{alu: a, bus: b, wr: w, inc: i, dm: dm, zw: zw, dn: dn, rdy: rdy};
        return v;
    endfunction

    function automatic vec_t v_empty();
        return mk(ALU_IDLE, BUS_DM, M_NONE, I_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic vec_t v_ready();
        return mk(ALU_IDLE, BUS_DM, M_NONE, I_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    function automatic vec_t v_fetch_operand();
        return mk(ALU_IDLE, BUS_DM, M_IR, I_PC, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic void push_jump();
        exp_q.push_back(v_fetch_operand());
        exp_q.push_back(mk(ALU_IDLE, BUS_IR, M_PC, I_NONE, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(v_empty());
    endfunction

    function automatic void push_skip();
        exp_q.push_back(mk(ALU_IDLE, BUS_DM, M_NONE, I_PC, 1'b0, 1'b0, 1'b0, 1'b0));
    endfunction

    // Instruction-level reference: execute-phase control vectors for an opcode.
    function automatic void model(input logic [7:0] op, input logic z);
        logic [3:0] n;
        n = op[7:4];
        exp_q.delete();
        case (op)
            8'h01: exp_q.push_back(mk(ALU_IDLE, BUS_DM, M_NONE, I_NONE, 1'b0, 1'b0, 1'b1, 1'b0));
            8'h02: exp_q.push_back(mk(CLR, BUS_DM, M_AC, I_NONE, 1'b0, 1'b1, 1'b0, 1'b0));
            8'h03: begin
                exp_q.push_back(v_fetch_operand());
                exp_q.push_back(mk(ALU_IDLE, BUS_IR, M_AR, I_NONE, 1'b0, 1'b0, 1'b0, 1'b0));
                exp_q.push_back(v_empty());
                exp_q.push_back(mk(ALU_IDLE, BUS_DM, M_R, I_NONE, 1'b0, 1'b0, 1'b0, 1'b0));
                exp_q.push_back(mk(PASS, BUS_R, M_AC, I_NONE, 1'b0, 1'b0, 1'b0, 1'b0));
            end
            8'h04: begin
                exp_q.push_back(v_empty());
                exp_q.push_back(mk(ALU_IDLE, BUS_DM, M_R, I_NONE, 1'b0, 1'b0, 1'b0, 1'b0));
                exp_q.push_back(mk(PASS, BUS_R, M_AC, I_NONE, 1'b0, 1'b0, 1'b0, 1'b0));
            end
            8'h05: begin
                exp_q.push_back(mk(ALU_IDLE, BUS_AC, M_R, I_NONE, 1'b0, 1'b0, 1'b0, 1'b0));
                exp_q.push_back(mk(ALU_IDLE, BUS_DM, M_NONE, I_NONE, 1'b1, 1'b0, 1'b0, 1'b0));
                exp_q.push_back(v_empty());
            end
            8'h06: begin
                exp_q.push_back(v_fetch_operand());
                exp_q.push_back(mk(ALU_IDLE, BUS_IR, M_AR, I_NONE, 1'b0, 1'b0, 1'b0, 1'b0));
                exp_q.push_back(mk(ALU_IDLE, BUS_AC, M_R, I_NONE, 1'b0, 1'b0, 1'b0, 1'b0));
                exp_q.push_back(mk(ALU_IDLE, BUS_DM, M_NONE, I_NONE, 1'b1, 1'b0, 1'b0, 1'b0));
                exp_q.push_back(v_empty());
            end
            8'h07: push_jump();
            8'h08: if (!z) push_jump(); else push_skip();
            8'h09: if (z) push_jump(); else push_skip();
            8'h0A: exp_q.push_back(mk(MUL, BUS_R, M_AC, I_NONE, 1'b0, 1'b1, 1'b0, 1'b0));
            8'h0B: exp_q.push_back(mk(ADD, BUS_R, M_AC, I_NONE, 1'b0, 1'b1, 1'b0, 1'b0));
            8'h0C: exp_q.push_back(mk(SUB, BUS_R, M_AC, I_NONE, 1'b0, 1'b1, 1'b0, 1'b0));
            8'h0D: exp_q.push_back(mk(INC, BUS_DM, M_AC, I_NONE, 1'b0, 1'b1, 1'b0, 1'b0));
            default: begin
                if (op[3:0] == 4'hF && n >= 4'd1 && n <= 4'd6) begin
                    case (n)
                        4'd1:    exp_q.push_back(mk(ALU_IDLE, BUS_AC, M_RL, I_NONE, 1'b0, 1'b0, 1'b0, 1'b0));
                        4'd2:    exp_q.push_back(mk(ALU_IDLE, BUS_AC, M_RP, I_NONE, 1'b0, 1'b0, 1'b0, 1'b0));
                        4'd3:    exp_q.push_back(mk(ALU_IDLE, BUS_AC, M_RQ, I_NONE, 1'b0, 1'b0, 1'b0, 1'b0));
                        4'd4:    exp_q.push_back(mk(ALU_IDLE, BUS_AC, M_RC, I_NONE, 1'b0, 1'b0, 1'b0, 1'b0));
                        4'd5:    exp_q.push_back(mk(ALU_IDLE, BUS_AC, M_R,  I_NONE, 1'b0, 1'b0, 1'b0, 1'b0));
                        default: exp_q.push_back(mk(ALU_IDLE, BUS_AC, M_R1, I_NONE, 1'b0, 1'b0, 1'b0, 1'b0));
                    endcase
                end else if (op == 8'h7F) begin
                    exp_q.push_back(mk(PASS, BUS_RP, M_AC, I_NONE, 1'b0, 1'b0, 1'b0, 1'b0));
                end else if (op == 8'h8F) begin
                    exp_q.push_back(mk(PASS, BUS_RQ, M_AC, I_NONE, 1'b0, 1'b0, 1'b0, 1'b0));
                end else if (op == 8'h9F) begin
                    exp_q.push_back(mk(PASS, BUS_RL, M_AC, I_NONE, 1'b0, 1'b0, 1'b0, 1'b0));
`ifdef INC_REGS_EN
                end else if (op == 8'hAF) begin
                    exp_q.push_back(mk(ALU_IDLE, BUS_DM, M_NONE, I_RC, 1'b0, 1'b0, 1'b0, 1'b0));
                end else if (op == 8'hBF) begin
                    exp_q.push_back(mk(ALU_IDLE, BUS_DM, M_NONE, I_RP, 1'b0, 1'b0, 1'b0, 1'b0));
                end else if (op == 8'hCF) begin
                    exp_q.push_back(mk(ALU_IDLE, BUS_DM, M_NONE, I_RQ, 1'b0, 1'b0, 1'b0, 1'b0));
`endif
                end else begin
                    exp_q.push_back(v_empty());
                end
            end
        endcase
    endfunction

    task automatic check(input vec_t e, input string tag);
        vec_t obs;
        obs = '{alu: aluOp, bus: busSel, wr: wrEnReg, inc: incReg,
                dm: DataMemWrEn, zw: ZWrEn, dn: done, rdy: ready};
        n_tests++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    // Check the current cycle's outputs, then drive the inputs that decide its exit.
    task automatic step(input vec_t e, input string tag, input logic st,
                        input logic [7:0] op, input logic z);
        @(negedge clk);
        check(e, tag);
        start = st;
        Zout  = z;
        ins   = IRW'($urandom);
        ins[7:0] = op;
    endtask

    // One full instruction starting at FETCH1; Zout is z only during decode.
    task automatic run_instr(input logic [7:0] op, input logic z, input string tag);
        int k;
        step(v_empty(), {tag, "/fetch1"}, rb(), 8'($urandom), rb());
        step(v_fetch_operand(), {tag, "/fetch2"}, rb(), 8'($urandom), rb());
        step(v_empty(), {tag, "/fetch3"}, rb(), op, z);
        model(op, z);
        while (exp_q.size() > 0) begin
            step(exp_q.pop_front(), {tag, "/exec"}, rb(), 8'($urandom), rb());
        end
        if (op == 8'h01) begin
            k = $urandom_range(1, 3);
            for (int j = 0; j < k; j++)
                step(v_ready(), {tag, "/idle"}, (j == k - 1), 8'($urandom), rb());
        end
    endtask

    initial begin
        logic [7:0] op;
        rstN  = 1'b0;
        start = 1'b0;
        Zout  = 1'b0;
        ins   = '0;
        repeat (2) @(negedge clk);
        check(v_ready(), "reset");
        rstN = 1'b1;
        step(v_ready(), "idle_no_start", 1'b1, 8'h00, 1'b0);

        run_instr(8'h00, 1'b0, "nop");
        run_instr(8'h03, 1'b1, "ldiac");
        run_instr(8'h09, 1'b1, "jmpz_taken");
        run_instr(8'h09, 1'b0, "jmpz_skip");
        run_instr(8'h08, 1'b0, "jmpnz_taken");
        run_instr(8'h08, 1'b1, "jmpnz_skip");
        run_instr(8'h05, 1'b0, "str");
        run_instr(8'h7F, 1'b0, "mv_ac_rp");
        run_instr(8'h1F, 1'b0, "mv_rl_ac");
        run_instr(8'h06, 1'b0, "stir");
        run_instr(8'h04, 1'b0, "ldac");
        run_instr(8'h02, 1'b1, "clac");
        run_instr(8'h0B, 1'b0, "add");
        run_instr(8'hAF, 1'b0, "incrc");
        run_instr(8'hEE, 1'b1, "unknown");
        run_instr(8'h01, 1'b0, "endop");

        // Asynchronous reset in the middle of LDIAC.
        step(v_empty(), "rst/fetch1", 1'b0, 8'h00, 1'b0);
        step(v_fetch_operand(), "rst/fetch2", 1'b0, 8'h00, 1'b0);
        step(v_empty(), "rst/fetch3", 1'b0, 8'h03, 1'b0);
        step(v_fetch_operand(), "rst/ldiac1", 1'b0, 8'h00, 1'b0);
        step(mk(ALU_IDLE, BUS_IR, M_AR, I_NONE, 1'b0, 1'b0, 1'b0, 1'b0), "rst/ldiac2", 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #2;
        rstN  = 1'b0;
        start = 1'b0;
        #1;
        check(v_ready(), "rst_async");
        @(negedge clk);
        check(v_ready(), "rst_held");
        rstN = 1'b1;
        step(v_ready(), "rst_release", 1'b1, 8'h00, 1'b0);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 2))
                0:       op = 8'($urandom_range(0, 13));
                1:       op = {4'($urandom_range(1, 12)), 4'hF};
                default: op = 8'($urandom);
            endcase
            run_instr(op, rb(), $sformatf("rnd%0d_op%02h", i, op));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Hardwired FSM control unit for one core of the multicore processor. Fetches each instruction into IR, decodes `ins` and sequences datapath control for the accumulator ISA: register write enables, increments, bus source, ALU op, data-memory write and Z-flag write. Sits beside the core datapath; `ready`/`done` handshake with the top-level scheduler.

Parameters:
IR_WIDTH, 8, width of `ins`; opcode is `ins[7:0]`; must be >= 8.

Ports:
- clk  in  1  rising-edge clock
- rstN  in  1  asynchronous active-low reset
- start  in  1  launch execution from IDLE
- Zout  in  1  datapath Z flag
- ins  in  IR_WIDTH  IR contents (opcode)
- aluOp  out  alu_op_t  ALU operation
- incReg  out  4  increments {PC,RC,RP,RQ} (bit3=PC)
- wrEnReg  out  10  write enables {AR,R,PC,IR,RL,RC,RP,RQ,R1,AC} (bit9=AR … bit0=AC)
- busSel  out  bus_in_sel_t  bus source
- DataMemWrEn  out  1  DM[AR] <= R
- ZWrEn  out  1  latch Z from ALU
- done  out  1  ENDOP reached
- ready  out  1  idle, awaiting start

Behaviour:
- Moore FSM. Outputs are a combinational function of state only, plus next state from ins/Zout.
- Defaults in every state: aluOp=ALU_IDLE, busSel=BUS_DM, all enables 0, done=0, ready=0.
- Reset (async, rstN=0) forces IDLE immediately; outputs = IDLE values (ready=1, all else default).
- IDLE: ready=1; start=1 -> FETCH1, else stay.
- FETCH1: wait (imem addressed by PC).
- FETCH2: wrEnReg[IR]=1, incReg[PC]=1.
- FETCH3: decode ins[7:0] and Zout -> first execute state. Unknown opcodes execute as NOP.
- Execute states return to FETCH1 unless noted. Totals include 3 fetch cycles.
- NOP(0x00), 4 cycles: one empty state.
- ENDOP(0x01), 4 cycles: one state with done=1, then IDLE.
- CLAC(0x02), 4 cycles: aluOp=CLR, wr AC, ZWrEn.
- LDIAC(0x03), 8 cycles:
  1. wr IR, inc PC (operand)
  2. busSel=IR, wr AR
  3. wait for DM read
  4. busSel=DM, wr R
  5. busSel=R, aluOp=PASS, wr AC
- LDAC(0x04), 6 cycles: wait; busSel=DM wr R; busSel=R PASS wr AC.
- STR(0x05), 6 cycles: busSel=AC wr R; DataMemWrEn; wait.
- STIR(0x06), 8 cycles: wr IR+inc PC; busSel=IR wr AR; busSel=AC wr R; DataMemWrEn; wait.
- JUMP(0x07), 6 cycles: wr IR+inc PC; busSel=IR wr PC; wait.
- JMPNZ(0x08): taken when Zout=0 (JUMP sequence, 6 cycles). Otherwise one state inc PC to skip operand (4 cycles).
- JMPZ(0x09): same, taken when Zout=1.
- MUL/ADD/SUB(0x0A/0B/0C), 4 cycles: busSel=R, aluOp=MUL/ADD/SUB, wr AC, ZWrEn.
- INCAC(0x0D), 4 cycles: aluOp=INC, wr AC, ZWrEn.
- MV_X_AC, 4 cycles: opcode {n,4'hF} for n=1..6 with X=RL,RP,RQ,RC,R,R1. busSel=AC, wr X.
- MV_AC_X, 4 cycles: opcode {n,4'hF} for n=7..9 with X=RP,RQ,RL. busSel=X, aluOp=PASS, wr AC.
- Zout is sampled only in FETCH3.
- start is ignored outside IDLE.
- Holding start=1 after ENDOP relaunches on the cycle after IDLE is entered.
- Reset mid-instruction aborts with no further enables.

Optional Feature:
INC_REGS_EN.
- Defined: opcodes {4'hA,4'hF}, {4'hB,4'hF}, {4'hC,4'hF} are INCRC/INCRP/INCRQ. Each is one execute state asserting incReg[RC]/[RP]/[RQ] (4 cycles total).
- Undefined: these opcodes decode as NOP, and incReg[2:0] is constantly 0.

Decomposition:
- Package `details`:
  - alu_op_t {ALU_IDLE, CLR, PASS, ADD, SUB, MUL, INC}
  - bus_in_sel_t {BUS_DM, BUS_R, BUS_IR, BUS_RL, BUS_RC, BUS_RP, BUS_RQ, BUS_R1, BUS_AC}
  - opcode localparams
  - wrEnReg/incReg bit-index constants
- Single module with no sub-module. The state enum is local.

Test Plan:
- Reset then start=1, ins=NOP: ready=1 in IDLE; IR write and PC inc in cycle 2 of fetch; next fetch begins exactly 4 cycles later.
- LDIAC: 8-cycle sequence. IR+PC, then AR(bus IR), wait, R(bus DM), AC(bus R, PASS) in the stated order; exactly one wrEn bit per write state.
- JMPZ with Zout=1: PC written from bus IR, 6 cycles. JMPZ with Zout=0: only inc PC, 4 cycles. JMPNZ is the mirror case.
- STR: R<=AC, then DataMemWrEn=1 for exactly one cycle, 6 cycles total.
- MV_AC_RP (0x7F): busSel=RP, aluOp=PASS, wrEnReg=10'b0000000001. MV_RL_AC (0x1F): busSel=AC, wrEnReg bit5 only.
- ENDOP: done=1 for one cycle, then IDLE with ready=1. rstN pulse mid-LDIAC returns to IDLE asynchronously.
